// File: rtl/load_sequencer.sv
// load_sequencer
// Turns one push-button into the sel/en load sequence for the LAB1
// register-load decoder: operand A, operand B, function, then a parked
// DONE state.
// The next qualified press from DONE wraps back to operand A.
//
// Optional feature macro: LOAD_SEQ_DEBOUNCE_EN
//   defined   -> a debounce filter of DEBOUNCE_CYCLES sits after the synchronizer
//   undefined -> the synchronized level feeds the edge detector directly
//
// All outputs come straight from flops. Reset is synchronous and active-low.
// i_clear is a synchronous abort back to operand A.

module load_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_step,
    input  logic       i_clear,
    output logic [1:0] o_sel,
    output logic       o_en,
    output logic       o_done
);

    // The state encoding doubles as the decoder select code.
    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        LOAD_F = 2'b10,
        DONE   = 2'b11
    } state_t;

    // Successor of a load state once its strobe has been issued.
    function automatic state_t f_advance(input state_t cur);
        state_t nxt;
        case (cur)
            LOAD_A:  nxt = LOAD_B;
            LOAD_B:  nxt = LOAD_F;
            LOAD_F:  nxt = DONE;
            DONE:    nxt = DONE;
            default: nxt = LOAD_A;
        endcase
        return nxt;
    endfunction

    // Input path: the synchronizer, the filtered level and the edge history.
    logic   r_s1;
    logic   r_s2;
    logic   w_filt;
    logic   r_filt_d;
    logic   w_rise;

    // State machine and the registered outputs.
    state_t r_state;
    state_t w_state_nxt;
    logic   r_en;
    logic   w_en_nxt;
    logic   r_done;
    logic   w_done_nxt;

    // Two-flop synchronizer for the asynchronous button level.
    // i_clear leaves it alone, so a button that is still held does not
    // retrigger after a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_step;
            r_s2 <= r_s1;
        end
    end

`ifdef LOAD_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_db_cnt;
    logic             r_filt;

    // Debounce filter.
    // The filtered level takes the s2 value once s2 has disagreed with it
    // for DEBOUNCE_CYCLES consecutive samples.
    // Any agreeing sample restarts the count.
    // The count stops at CNT_LAST and never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_db_cnt <= {CNT_W{1'b0}};
            r_filt   <= 1'b0;
        end else if (r_s2 == r_filt) begin
            r_db_cnt <= {CNT_W{1'b0}};
            r_filt   <= r_filt;
        end else if (r_db_cnt >= CNT_LAST) begin
            r_db_cnt <= {CNT_W{1'b0}};
            r_filt   <= r_s2;
        end else begin
            r_db_cnt <= r_db_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_filt   <= r_filt;
        end
    end

    assign w_filt = r_filt;
`else
    // Without the filter, the synchronized level is used as-is.
    assign w_filt = r_s2;
`endif

    // Edge-history register for the rising-edge detector.
    // It keeps tracking during i_clear, so a discarded edge is not seen again.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    assign w_rise = w_filt & ~r_filt_d;

    // Next-state and next-output logic.
    // An active strobe always retires (the state advances) before another
    // press can be acted on. A press in DONE only wraps back to operand A.
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        if (i_clear) begin
            w_state_nxt = LOAD_A;
            w_en_nxt    = 1'b0;
        end else if (r_en) begin
            w_state_nxt = f_advance(r_state);
            w_en_nxt    = 1'b0;
        end else if (w_rise) begin
            if (r_state == DONE) begin
                w_state_nxt = LOAD_A;
                w_en_nxt    = 1'b0;
            end else begin
                w_state_nxt = r_state;
                w_en_nxt    = 1'b1;
            end
        end else begin
            w_state_nxt = r_state;
            w_en_nxt    = 1'b0;
        end
        w_done_nxt = (w_state_nxt == DONE) ? 1'b1 : 1'b0;
    end

    // State register and the registered outputs.
    // A reset during an en pulse cuts the pulse short and counts no load.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= LOAD_A;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_sel  = r_state;
    assign o_en   = r_en;
    assign o_done = r_done;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer.
// Each press that should produce a load strobe pushes {sel, cycle} onto a
// scoreboard queue.
// Every cycle, en must be high exactly when the head entry is due, and sel
// must match that entry.

module tb_load_sequencer;

    localparam int D = 4;
`ifdef LOAD_SEQ_DEBOUNCE_EN
    localparam int LAT = 3 + D;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [1:0] sel;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic       step;
    logic       clear;
    logic [1:0] o_sel;
    logic       o_en;
    logic       o_done;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    load_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_step  (step),
        .i_clear (clear),
        .o_sel   (o_sel),
        .o_en    (o_en),
        .o_done  (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] sel, input int due);
        exp_t e;
        e.sel = sel;
        e.cyc = due;
        q.push_back(e);
    endtask

    // Advance one clock edge, then check en/sel against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() != 0 && q[0].cyc == cyc) begin
            chk("en_pulse", {31'd0, o_en}, 32'd1);
            chk("en_sel", {30'd0, o_sel}, {30'd0, q[0].sel});
            void'(q.pop_front());
        end else begin
            chk("en_idle", {31'd0, o_en}, 32'd0);
        end
    endtask

    task automatic press(input logic expect_pulse, input logic [1:0] sel, input int hold, input int gap);
        step = 1'b1;
        if (expect_pulse) push_exp(sel, cyc + LAT);
        repeat (hold) tick();
        step = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        step   = 1'b1;
        clear  = 1'b0;

        // Reset held with the button pressed.
        repeat (3) tick();
        chk("rst_sel", {30'd0, o_sel}, 32'd0);
        chk("rst_en", {31'd0, o_en}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);

        // Release reset with the button still held: one pulse on operand A.
        rstn = 1'b1;
        push_exp(2'b00, cyc + LAT);
        repeat (LAT + 5) tick();
        chk("rst_rel_sel", {30'd0, o_sel}, 32'd1);
        chk("rst_rel_done", {31'd0, o_done}, 32'd0);
        step = 1'b0;
        repeat (10) tick();

        // Clear with no edge pending returns to operand A.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_idle_sel", {30'd0, o_sel}, 32'd0);

        // Full sequence: A, B, F, then a wrap press that gives no pulse.
        press(1'b1, 2'b00, 5, 5);
        press(1'b1, 2'b01, 5, 5);
        press(1'b1, 2'b10, 5, 5);
        chk("seq_done_sel", {30'd0, o_sel}, 32'd3);
        chk("seq_done", {31'd0, o_done}, 32'd1);
        press(1'b0, 2'b00, 5, 5);
        chk("wrap_sel", {30'd0, o_sel}, 32'd0);
        chk("wrap_done", {31'd0, o_done}, 32'd0);

        // Held button: one pulse only.
        press(1'b1, 2'b00, 100, 10);
        chk("held_sel", {30'd0, o_sel}, 32'd1);

        // Clear on the edge that would start the LOAD_B pulse.
        step = 1'b1;
        repeat (LAT - 1) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_col_sel", {30'd0, o_sel}, 32'd0);
        repeat (10) tick();
        chk("clr_hold_sel", {30'd0, o_sel}, 32'd0);
        step = 1'b0;
        repeat (10) tick();
        press(1'b1, 2'b00, 5, 5);
        chk("after_clr_sel", {30'd0, o_sel}, 32'd1);

        // Move to LOAD_F, then reset in the middle of its pulse.
        press(1'b1, 2'b01, 5, 5);
        chk("pre_f_sel", {30'd0, o_sel}, 32'd2);
        step = 1'b1;
        push_exp(2'b10, cyc + LAT);
        repeat (LAT) tick();
        rstn = 1'b0;
        step = 1'b0;
        tick();
        chk("rst_mid_en", {31'd0, o_en}, 32'd0);
        chk("rst_mid_sel", {30'd0, o_sel}, 32'd0);
        chk("rst_mid_done", {31'd0, o_done}, 32'd0);
        rstn = 1'b1;
        repeat (10) tick();
        chk("post_rst_sel", {30'd0, o_sel}, 32'd0);

`ifdef LOAD_SEQ_DEBOUNCE_EN
        // Chatter every cycle is rejected; a steady press is accepted once.
        for (int i = 0; i < 20; i++) begin
            step = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        step = 1'b0;
        chk("chatter_sel", {30'd0, o_sel}, 32'd0);
        press(1'b1, 2'b00, 15, 15);
        chk("db_sel", {30'd0, o_sel}, 32'd1);
`endif

        repeat (5) tick();
        chk("queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
